// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable Moore sequence detector with hit budget and window.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; non-overlapping otherwise.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_max_hits,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             d_valid,
  input  logic             d_in,
  output logic             d_out,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_MATCH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d;
  logic [LEN_W-1:0] len_q, len_d, bits_q, bits_d;
  logic [CNT_W-1:0] max_q, max_d, hit_q, hit_d;
  logic [WIN_W-1:0] win_q, win_d, win_cnt_q, win_cnt_d;
  logic             timeout_q, timeout_d;

  logic [PAT_W-1:0] mask, hist_shift;
  logic [LEN_W:0]   bits_inc;
  logic [LEN_W-1:0] bits_sat, eff_len;
  logic [WIN_W-1:0] win_inc;
  logic [CNT_W-1:0] hit_inc;
  logic             match, expire, win_full, budget;

  always_comb begin
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    hist_shift = {hist_q[PAT_W-2:0], d_in};
    bits_inc   = {1'b0, bits_q} + (LEN_W+1)'(1);
    bits_sat   = (bits_q >= len_q) ? len_q : bits_inc[LEN_W-1:0];
    match      = (bits_inc >= {1'b0, len_q}) && ((hist_shift & mask) == (pat_q & mask));
    win_inc    = win_cnt_q + WIN_W'(1);
    expire     = (win_q != '0) && (win_inc == win_q);
    win_full   = (win_q != '0) && (win_cnt_q == win_q);
    budget     = (max_q != '0) && (hit_q == max_q);
    hit_inc    = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
    if (cfg_len == '0)                    eff_len = LEN_W'(1);
    else if (cfg_len > LEN_W'(PAT_W))     eff_len = LEN_W'(PAT_W);
    else                                  eff_len = cfg_len;
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    max_d     = max_q;
    win_d     = win_q;
    hist_d    = hist_q;
    bits_d    = bits_q;
    hit_d     = hit_q;
    win_cnt_d = win_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_RUN;
          pat_d     = cfg_pattern;
          len_d     = eff_len;
          max_d     = cfg_max_hits;
          win_d     = cfg_window;
          hist_d    = '0;
          bits_d    = '0;
          hit_d     = '0;
          win_cnt_d = '0;
          timeout_d = 1'b0;
        end
      end
      S_RUN, S_MATCH: begin
        if (abort) begin
          state_d = S_DONE;
        // A window filled by a matching bit ends the run once the MATCH pulse is out.
        end else if (state_q == S_MATCH && (budget || win_full)) begin
          state_d = S_DONE;
        end else if (d_valid) begin
          win_cnt_d = win_inc;
          if (match) begin
            state_d = S_MATCH;
            hit_d   = hit_inc;
            hist_d  = OVERLAP ? hist_shift : '0;
            bits_d  = OVERLAP ? bits_sat : '0;
          end else begin
            hist_d  = hist_shift;
            bits_d  = bits_sat;
            if (expire) begin
              state_d   = S_DONE;
              timeout_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      max_q     <= '0;
      win_q     <= '0;
      hist_q    <= '0;
      bits_q    <= '0;
      hit_q     <= '0;
      win_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      max_q     <= max_d;
      win_q     <= win_d;
      hist_q    <= hist_d;
      bits_q    <= bits_d;
      hit_q     <= hit_d;
      win_cnt_q <= win_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign d_out     = (state_q == S_MATCH);
  assign busy      = (state_q == S_RUN) || (state_q == S_MATCH);
  assign done      = (state_q == S_DONE);
  assign timeout   = timeout_q;
  assign hit_count = hit_q;

endmodule
